pipeline_sequencer: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It merges the ID-stage `hazard_Detected` and `Br_taken` outputs with MEM-stage memory requests and the SRAM `sram_ready` handshake into per-stage freeze, flush and start controls. It runs a small FSM that holds the whole pipeline while a multi-cycle SRAM access is outstanding, enforces a watchdog timeout, and keeps a stall-cycle performance counter.

---
 rtl/pipeline_sequencer.sv | 99 +++++++++
 tb/tb_pipeline_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer: merges ID hazard/branch flags with MEM-stage SRAM
// accesses into per-stage freeze, flush and start controls.
module pipeline_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int STALL_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hazard_Detected,
  input  logic               Br_taken,
  input  logic               Mem_R_EN_mem,
  input  logic               Mem_W_EN_mem,
  input  logic               sram_ready,
  output logic               mem_start,
  output logic               freeze_pc,
  output logic               freeze_if_id,
  output logic               freeze_back,
  output logic               flush_if_id,
  output logic               mem_busy,
  output logic               timeout_err,
  output logic [STALL_W-1:0] stall_cycles
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, MEM_WAIT, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout_err_q, timeout_err_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_req;
  logic mem_hold;
  logic freeze_back_raw;
  logic freeze_pc_raw;

  assign mem_req = Mem_R_EN_mem | Mem_W_EN_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    stall_cnt_d   = stall_cnt_q;
    case (state_q)
      IDLE:     if (mem_req) state_d = START;
      START: begin
        wait_cnt_d = '0;
        state_d    = MEM_WAIT;
      end
      MEM_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // A ready in the last allowed cycle still counts as a normal completion
        if (sram_ready) begin
          state_d = RELEASE;
        end else if (wait_cnt_q == LAST_CNT) begin
          timeout_err_d = 1'b1;
          state_d       = RELEASE;
        end
      end
      RELEASE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (freeze_pc_raw && (stall_cnt_q != {STALL_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  always_comb begin
    mem_hold        = (state_q == START) || (state_q == MEM_WAIT);
    freeze_back_raw = mem_hold || ((state_q == IDLE) && mem_req);
    freeze_pc_raw   = freeze_back_raw || hazard_Detected;

    // Every output is forced low while reset is asserted
    mem_start    = !rst && (state_q == START);
    mem_busy     = !rst && mem_hold;
    freeze_back  = !rst && freeze_back_raw;
    freeze_pc    = !rst && freeze_pc_raw;
    freeze_if_id = !rst && freeze_pc_raw;
    flush_if_id  = !rst && Br_taken && !hazard_Detected && !freeze_back_raw;
    timeout_err  = !rst && timeout_err_q;
    stall_cycles = rst ? '0 : stall_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed testbench for pipeline_sequencer (TIMEOUT=4 so the watchdog is reachable quickly).
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_Detected, Br_taken, Mem_R_EN_mem, Mem_W_EN_mem, sram_ready;
  logic        mem_start, freeze_pc, freeze_if_id, freeze_back, flush_if_id;
  logic        mem_busy, timeout_err;
  logic [31:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_sequencer #(.TIMEOUT(4), .STALL_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard_Detected (hazard_Detected),
    .Br_taken        (Br_taken),
    .Mem_R_EN_mem    (Mem_R_EN_mem),
    .Mem_W_EN_mem    (Mem_W_EN_mem),
    .sram_ready      (sram_ready),
    .mem_start       (mem_start),
    .freeze_pc       (freeze_pc),
    .freeze_if_id    (freeze_if_id),
    .freeze_back     (freeze_back),
    .flush_if_id     (flush_if_id),
    .mem_busy        (mem_busy),
    .timeout_err     (timeout_err),
    .stall_cycles    (stall_cycles)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic r, input logic hz, input logic br,
                            input logic rd, input logic wr, input logic rdy);
    rst = r; hazard_Detected = hz; Br_taken = br;
    Mem_R_EN_mem = rd; Mem_W_EN_mem = wr; sram_ready = rdy;
  endtask

  task automatic do_reset();
    set_inputs(1, 0, 0, 0, 0, 0);
    next_cycle();
    set_inputs(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) set_inputs(1, 1, 1, 1, 1, 1);
      else       set_inputs(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      obs = {mem_start, freeze_pc, freeze_if_id, freeze_back, flush_if_id, mem_busy, timeout_err};
      total++;
      if (obs !== 7'b0) begin
        bad++;
        $display("[TB] FAIL reset_outputs c%0d got=%b want=0000000", c, obs);
      end
      total++;
      if (stall_cycles !== 32'd0) begin
        bad++;
        $display("[TB] FAIL reset_stall c%0d got=%0d want=0", c, stall_cycles);
      end
      next_cycle();
    end
  endtask

  task automatic test_hazard();
    logic [2:0] obs, exp;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_inputs(0, (c < 2), 0, 0, 0, 0);
      @(negedge clk);
      obs = {freeze_pc, freeze_if_id, freeze_back};
      exp = (c < 2) ? 3'b110 : 3'b000;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL hazard_freeze c%0d {pc,ifid,back} got=%b want=%b", c, obs, exp);
      end
      next_cycle();
    end
    @(negedge clk);
    total++;
    if (stall_cycles !== 32'd2) begin
      bad++;
      $display("[TB] FAIL hazard_stall got=%0d want=2", stall_cycles);
    end
  endtask

  task automatic test_branch();
    logic [1:0] obs, exp;
    do_reset();
    for (int c = 1; c <= 2; c++) begin
      set_inputs(0, (c == 1), 1, 0, 0, 0);
      @(negedge clk);
      obs = {flush_if_id, freeze_pc};
      exp = (c == 1) ? 2'b01 : 2'b10;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL branch_flush c%0d {flush,fpc} got=%b want=%b", c, obs, exp);
      end
      next_cycle();
    end
    set_inputs(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load();
    logic [3:0] obs, exp;
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      // Ready pulses outside MEM_WAIT (cycles 0,1) must be ignored
      set_inputs(0, 0, 0, (c <= 6), 0, (c == 0 || c == 1 || c == 5));
      @(negedge clk);
      obs = {mem_start, freeze_back, freeze_pc, mem_busy};
      exp = {(c == 1), (c <= 5), (c <= 5), (c >= 1 && c <= 5)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL load c%0d {start,fback,fpc,busy} got=%b want=%b", c, obs, exp);
      end
      next_cycle();
    end
    set_inputs(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stall_cycles !== 32'd6) begin
      bad++;
      $display("[TB] FAIL load_stall got=%0d want=6", stall_cycles);
    end
    total++;
    if (timeout_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load_no_timeout got=%b want=0", timeout_err);
    end
  endtask

  task automatic test_timeout();
    logic [3:0] obs, exp;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      set_inputs(0, 0, 0, 0, (c <= 6), 0);
      @(negedge clk);
      obs = {mem_start, freeze_back, mem_busy, timeout_err};
      exp = {(c == 1), (c <= 5), (c >= 1 && c <= 5), (c >= 6)};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL timeout c%0d {start,fback,busy,terr} got=%b want=%b", c, obs, exp);
      end
      next_cycle();
    end
    set_inputs(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [2:0]  obs3, exp3;
    logic [6:0]  obs7;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      set_inputs(0, 0, 0, 1, 0, (c == 2));
      @(negedge clk);
      obs3 = {mem_start, freeze_back, mem_busy};
      exp3 = {(c == 1 || c == 5), (c != 3), (c == 1 || c == 2 || c == 5)};
      total++;
      if (obs3 !== exp3) begin
        bad++;
        $display("[TB] FAIL b2b c%0d {start,fback,busy} got=%b want=%b", c, obs3, exp3);
      end
      next_cycle();
    end
    // Cycle 6 is the first MEM_WAIT of the second load: reset it mid-access
    for (int c = 6; c <= 8; c++) begin
      set_inputs((c == 6), 0, 0, 0, 0, 0);
      @(negedge clk);
      obs7 = {mem_start, freeze_pc, freeze_if_id, freeze_back, flush_if_id, mem_busy, timeout_err};
      total++;
      if (obs7 !== 7'b0) begin
        bad++;
        $display("[TB] FAIL b2b_reset c%0d got=%b want=0000000", c, obs7);
      end
      total++;
      if (stall_cycles !== 32'd0) begin
        bad++;
        $display("[TB] FAIL b2b_reset_stall c%0d got=%0d want=0", c, stall_cycles);
      end
      next_cycle();
    end
  endtask

  initial begin
    set_inputs(1, 0, 0, 0, 0, 0);
    #1;
    test_reset();
    test_hazard();
    test_branch();
    test_load();
    test_timeout();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
